// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the address byte-select helper used by the
// receive filter.
package eth_pkg;

    localparam int          MAC_ADDR_WIDTH     = 48;
    localparam logic [47:0] ETH_BROADCAST_ADDR = 48'hFFFF_FFFF_FFFF;
    localparam int          ETH_MIN_HDR_BYTES  = 6;

    // Wire byte idx of a MAC address; byte 0 is the most significant octet.
    function automatic logic [7:0] mac_byte(input logic [MAC_ADDR_WIDTH-1:0] mac,
                                            input logic [2:0] idx);
        case (idx)
            3'd0:    mac_byte = mac[47:40];
            3'd1:    mac_byte = mac[39:32];
            3'd2:    mac_byte = mac[31:24];
            3'd3:    mac_byte = mac[23:16];
            3'd4:    mac_byte = mac[15:8];
            3'd5:    mac_byte = mac[7:0];
            default: mac_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/eth_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port,
// no reset on the storage or the read register.
module eth_frame_ram #(
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int WIDTH      = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while rd_en is low
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward receive filter: buffers each frame, checks the destination
// address on the fly and only releases accepted frames to the output stream.
module eth_rx_frame_filter
    import eth_pkg::*;
#(
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic [7:0]                m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    input  logic [MAC_ADDR_WIDTH-1:0] local_mac,
    input  logic                      promisc,
    input  logic                      accept_multicast,
    output logic                      frame_accepted,
    output logic                      drop_bad_frame,
    output logic                      drop_addr_mismatch,
    output logic                      drop_overflow
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [2:0]          MIN_HDR   = 3'(ETH_MIN_HDR_BYTES);

    logic [ADDR_WIDTH:0] wr_ptr_r, commit_ptr_r, rd_ptr_r, used_s;
    logic [2:0]          byte_cnt_r, cnt_next_s;
    logic                uc_match_r, bc_match_r, mc_r, ovf_r;
    logic                uc_next_s, bc_next_s, mc_next_s, ovf_next_s;
    logic                full_s, empty_s, wr_en_s, len_ok_s, addr_ok_s, accept_s, eof_s;
    logic                rd_en_s, out_ready_s, ram_vld_r;
    logic [8:0]          ram_q_s;

    assign used_s      = wr_ptr_r - rd_ptr_r;
    assign full_s      = (used_s == DEPTH_CNT);
    assign empty_s     = (commit_ptr_r == rd_ptr_r);
    assign eof_s       = s_axis_tvalid & s_axis_tlast;
    assign out_ready_s = ~m_axis_tvalid | m_axis_tready;
    assign rd_en_s     = ~empty_s & (~ram_vld_r | out_ready_s);

    // Header compare, overflow tracking and the accept decision for this byte
    always_comb begin
        uc_next_s  = uc_match_r;
        bc_next_s  = bc_match_r;
        mc_next_s  = mc_r;
        cnt_next_s = byte_cnt_r;
        if (byte_cnt_r < MIN_HDR) begin
            uc_next_s  = ((byte_cnt_r == 3'd0) | uc_match_r) &
                         (s_axis_tdata == mac_byte(local_mac, byte_cnt_r));
            bc_next_s  = ((byte_cnt_r == 3'd0) | bc_match_r) &
                         (s_axis_tdata == mac_byte(ETH_BROADCAST_ADDR, byte_cnt_r));
            mc_next_s  = (byte_cnt_r == 3'd0) ? s_axis_tdata[0] : mc_r;
            cnt_next_s = byte_cnt_r + 3'd1;
        end else begin
            cnt_next_s = byte_cnt_r;
        end
        ovf_next_s = ovf_r | full_s;
        wr_en_s    = s_axis_tvalid & ~ovf_next_s;
        len_ok_s   = (cnt_next_s >= MIN_HDR);
        addr_ok_s  = promisc | uc_next_s | bc_next_s | (mc_next_s & accept_multicast);
        accept_s   = eof_s & ~s_axis_tuser & ~ovf_next_s & len_ok_s & addr_ok_s;
    end

    // Write-side pointers and per-frame state; a rejected frame rewinds to commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= '0;
            commit_ptr_r <= '0;
            byte_cnt_r   <= 3'd0;
            uc_match_r   <= 1'b0;
            bc_match_r   <= 1'b0;
            mc_r         <= 1'b0;
            ovf_r        <= 1'b0;
        end else if (eof_s) begin
            byte_cnt_r <= 3'd0;
            uc_match_r <= 1'b0;
            bc_match_r <= 1'b0;
            mc_r       <= 1'b0;
            ovf_r      <= 1'b0;
            if (accept_s) begin
                wr_ptr_r     <= wr_ptr_r + 1'b1;
                commit_ptr_r <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r <= commit_ptr_r;
            end
        end else if (s_axis_tvalid) begin
            byte_cnt_r <= cnt_next_s;
            uc_match_r <= uc_next_s;
            bc_match_r <= bc_next_s;
            mc_r       <= mc_next_s;
            ovf_r      <= ovf_next_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
        end
    end

    // Status pulses; drop reasons are mutually exclusive, overflow first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_accepted     <= 1'b0;
            drop_bad_frame     <= 1'b0;
            drop_addr_mismatch <= 1'b0;
            drop_overflow      <= 1'b0;
        end else begin
            frame_accepted     <= accept_s;
            drop_overflow      <= eof_s & ovf_next_s;
            drop_bad_frame     <= eof_s & ~ovf_next_s & s_axis_tuser;
            drop_addr_mismatch <= eof_s & ~ovf_next_s & ~s_axis_tuser & ~(len_ok_s & addr_ok_s);
        end
    end

    eth_frame_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (9)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r[ADDR_WIDTH-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r[ADDR_WIDTH-1:0]),
        .rd_data (ram_q_s)
    );

    // Read pointer and RAM-output occupancy; a held RAM word waits for the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r  <= '0;
            ram_vld_r <= 1'b0;
        end else if (rd_en_s) begin
            rd_ptr_r  <= rd_ptr_r + 1'b1;
            ram_vld_r <= 1'b1;
        end else if (out_ready_s) begin
            ram_vld_r <= 1'b0;
        end else begin
            ram_vld_r <= ram_vld_r;
        end
    end

    // Output register of the fall-through stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'h00;
            m_axis_tlast  <= 1'b0;
        end else if (out_ready_s & ram_vld_r) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ram_q_s[7:0];
            m_axis_tlast  <= ram_q_s[8];
        end else if (out_ready_s) begin
            m_axis_tvalid <= 1'b0;
        end else begin
            m_axis_tvalid <= m_axis_tvalid;
        end
    end

endmodule
